// File: rtl/rm_violation_collector.sv
// rm_violation_collector: collects per-lane rule violations from rm_monitor,
// edge-detects them, arbitrates lanes round-robin and queues one record per
// grant into a small FIFO drained by the trap/CSR side over valid/ready.
module rm_violation_collector #(
  parameter int NUM_LANES  = 4,
  parameter int NUM_RULES  = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = 16,
  localparam int LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_LANES*NUM_RULES-1:0] monitor_i,
  input  logic [NUM_LANES-1:0]           lane_reset_i,
  output logic                           viol_valid_o,
  input  logic                           viol_ready_i,
  output logic [LW-1:0]                  viol_lane_o,
  output logic [NUM_RULES-1:0]           viol_rules_o,
  output logic [TS_W-1:0]                viol_time_o,
  output logic [NUM_LANES-1:0]           lane_release_o,
  output logic                           irq_o,
  output logic [7:0]                     drop_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Per-lane violation state
  logic [NUM_LANES-1:0][NUM_RULES-1:0] seen_q, seen_d;
  logic [NUM_LANES-1:0][NUM_RULES-1:0] pending_q, pending_d;
  logic [NUM_LANES-1:0][NUM_RULES-1:0] new_bits;
  logic [NUM_LANES-1:0]                cand;

  // Arbitration
  logic [LW-1:0]        rr_q, rr_d;
  logic [LW-1:0]        grant;
  logic                 grant_vld;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic [NUM_LANES-1:0] release_q, release_d;

  // Record FIFO
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [LW-1:0]        mem_lane_q  [FIFO_DEPTH];
  logic [LW-1:0]        mem_lane_d  [FIFO_DEPTH];
  logic [NUM_RULES-1:0] mem_rules_q [FIFO_DEPTH];
  logic [NUM_RULES-1:0] mem_rules_d [FIFO_DEPTH];
  logic [TS_W-1:0]      mem_ts_q    [FIFO_DEPTH];
  logic [TS_W-1:0]      mem_ts_d    [FIFO_DEPTH];

  // Misc counters
  logic [TS_W-1:0] ts_q, ts_d;
  logic [7:0]      drop_q, drop_d;

  // Rising violation bits per lane and which lanes may compete for a slot
  always_comb begin
    new_bits = '0;
    cand     = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      new_bits[l] = monitor_i[l*NUM_RULES +: NUM_RULES] & ~seen_q[l];
      cand[l]     = (pending_q[l] != '0) && !lane_reset_i[l];
    end
  end

  // Round-robin grant: first candidate at/after rr_q, else first from lane 0
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!grant_vld && cand[i] && (LW'(i) >= rr_q)) begin
        grant_vld = 1'b1;
        grant     = LW'(i);
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!grant_vld && cand[i]) begin
        grant_vld = 1'b1;
        grant     = LW'(i);
      end
    end
  end

  // A full FIFO can still accept a record when its head leaves this cycle
  always_comb begin
    full = (count_q == CW'(FIFO_DEPTH));
    pop  = (count_q != '0) && viol_ready_i;
    push = grant_vld && (!full || pop);
  end

  // Lane state update: lane reset wins; a granted lane keeps only bits that
  // arrive in the grant cycle so nothing is lost
  always_comb begin
    seen_d    = seen_q;
    pending_d = pending_q;
    drop_d    = drop_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (lane_reset_i[l]) begin
        seen_d[l]    = '0;
        pending_d[l] = '0;
        if ((pending_q[l] != '0) && (drop_d != 8'hFF)) begin
          drop_d = drop_d + 8'd1;
        end
      end else begin
        seen_d[l] = seen_q[l] | monitor_i[l*NUM_RULES +: NUM_RULES];
        if (push && (grant == LW'(l))) begin
          pending_d[l] = new_bits[l];
        end else begin
          pending_d[l] = pending_q[l] | new_bits[l];
        end
      end
    end
  end

  // Round-robin pointer, release pulse and free-running timestamp
  always_comb begin
    rr_d      = rr_q;
    release_d = '0;
    if (push) begin
      rr_d           = (grant == LW'(NUM_LANES - 1)) ? '0 : grant + LW'(1);
      release_d[grant] = 1'b1;
    end
    ts_d = ts_q + TS_W'(1);
  end

  // FIFO write, pointer and occupancy update
  always_comb begin
    mem_lane_d  = mem_lane_q;
    mem_rules_d = mem_rules_q;
    mem_ts_d    = mem_ts_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      mem_lane_d[wr_ptr_q]  = grant;
      mem_rules_d[wr_ptr_q] = pending_q[grant];
      mem_ts_d[wr_ptr_q]    = ts_q;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // State registers; asynchronous reset discards queue and lane state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seen_q    <= '0;
      pending_q <= '0;
      rr_q      <= '0;
      release_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ts_q      <= '0;
      drop_q    <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        mem_lane_q[e]  <= '0;
        mem_rules_q[e] <= '0;
        mem_ts_q[e]    <= '0;
      end
    end else begin
      seen_q      <= seen_d;
      pending_q   <= pending_d;
      rr_q        <= rr_d;
      release_q   <= release_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ts_q        <= ts_d;
      drop_q      <= drop_d;
      mem_lane_q  <= mem_lane_d;
      mem_rules_q <= mem_rules_d;
      mem_ts_q    <= mem_ts_d;
    end
  end

  assign viol_valid_o   = (count_q != '0);
  assign irq_o          = (count_q != '0);
  assign viol_lane_o    = mem_lane_q[rd_ptr_q];
  assign viol_rules_o   = mem_rules_q[rd_ptr_q];
  assign viol_time_o    = mem_ts_q[rd_ptr_q];
  assign lane_release_o = release_q;
  assign drop_cnt_o     = drop_q;

endmodule

// File: tb/tb_rm_violation_collector.sv
// Directed bench for rm_violation_collector: latency, edge detection,
// round-robin order, backpressure/coalescing, drop counting, async reset
// and timestamp wrap.
module tb_rm_violation_collector;

  localparam int NL  = 4;
  localparam int NR  = 5;
  localparam int TSW = 16;
  localparam int LW  = 2;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NL*NR-1:0]  monitor = '0;
  logic [NL-1:0]     lane_reset = '0;
  logic              ready = 1'b0;
  logic              viol_valid;
  logic [LW-1:0]     viol_lane;
  logic [NR-1:0]     viol_rules;
  logic [TSW-1:0]    viol_time;
  logic [NL-1:0]     lane_release;
  logic              irq;
  logic [7:0]        drop_cnt;

  int tests = 0;
  int fails = 0;

  rm_violation_collector #(
    .NUM_LANES (NL),
    .NUM_RULES (NR),
    .FIFO_DEPTH(4),
    .TS_W      (TSW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .monitor_i     (monitor),
    .lane_reset_i  (lane_reset),
    .viol_valid_o  (viol_valid),
    .viol_ready_i  (ready),
    .viol_lane_o   (viol_lane),
    .viol_rules_o  (viol_rules),
    .viol_time_o   (viol_time),
    .lane_release_o(lane_release),
    .irq_o         (irq),
    .drop_cnt_o    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_lane(input int l, input logic [NR-1:0] m);
    monitor[l*NR +: NR] = m;
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    monitor    = '0;
    lane_reset = '0;
    ready      = 1'b0;
    step(2);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    step(2);
    tests++; if (viol_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%0b exp=0", viol_valid); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_irq got=%0b exp=0", irq); end
    tests++; if (viol_lane !== 2'd0) begin fails++; $display("FAIL rst_lane got=%0d exp=0", viol_lane); end
    tests++; if (viol_rules !== 5'd0) begin fails++; $display("FAIL rst_rules got=%0h exp=0", viol_rules); end
    tests++; if (viol_time !== 16'd0) begin fails++; $display("FAIL rst_time got=%0h exp=0", viol_time); end
    tests++; if (lane_release !== 4'd0) begin fails++; $display("FAIL rst_release got=%0h exp=0", lane_release); end
    tests++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt); end
    rst_ni = 1'b1;
  endtask

  task automatic test_single_lane();
    ready = 1'b1;
    set_lane(2, 5'b00001);
    step(1);
    tests++; if (viol_valid !== 1'b0) begin fails++; $display("FAIL t1_early_valid got=%0b exp=0", viol_valid); end
    step(1);
    tests++; if (viol_valid !== 1'b1) begin fails++; $display("FAIL t1_valid got=%0b exp=1", viol_valid); end
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL t1_irq got=%0b exp=1", irq); end
    tests++; if (viol_lane !== 2'd2) begin fails++; $display("FAIL t1_lane got=%0d exp=2", viol_lane); end
    tests++; if (viol_rules !== 5'b00001) begin fails++; $display("FAIL t1_rules got=%0b exp=00001", viol_rules); end
    tests++; if (lane_release !== 4'b0100) begin fails++; $display("FAIL t1_release got=%0b exp=0100", lane_release); end
    for (int k = 0; k < 4; k++) begin
      step(1);
      tests++; if (viol_valid !== 1'b0) begin fails++; $display("FAIL t1_after_valid[%0d] got=%0b exp=0", k, viol_valid); end
      tests++; if (lane_release !== 4'b0000) begin fails++; $display("FAIL t1_after_release[%0d] got=%0b exp=0000", k, lane_release); end
    end
  endtask

  task automatic test_edge_detect();
    int            rec;
    logic [LW-1:0] lane_seen;
    logic [NR-1:0] rules_seen;
    ready = 1'b1;
    rec = 0; lane_seen = '1; rules_seen = '0;
    set_lane(0, 5'b01000);
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (viol_valid) begin rec++; lane_seen = viol_lane; rules_seen = viol_rules; end
    end
    tests++; if (rec !== 1) begin fails++; $display("FAIL t2_held_records got=%0d exp=1", rec); end
    tests++; if (lane_seen !== 2'd0) begin fails++; $display("FAIL t2_held_lane got=%0d exp=0", lane_seen); end
    tests++; if (rules_seen !== 5'b01000) begin fails++; $display("FAIL t2_held_rules got=%0b exp=01000", rules_seen); end
    set_lane(0, 5'b00000);
    step(1);
    lane_reset[0] = 1'b1;
    step(1);
    lane_reset[0] = 1'b0;
    set_lane(0, 5'b01000);
    rec = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (viol_valid) rec++;
    end
    tests++; if (rec !== 1) begin fails++; $display("FAIL t2_reraise_records got=%0d exp=1", rec); end
    tests++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL t2_drop got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int l = 0; l < NL; l++) set_lane(l, 5'b00010);
    step(1);
    for (int k = 0; k < NL; k++) begin
      step(1);
      tests++; if (lane_release !== 4'(1 << k)) begin fails++; $display("FAIL t3_fill_release[%0d] got=%0b exp=%0b", k, lane_release, 4'(1 << k)); end
    end
    ready = 1'b1;
    for (int k = 0; k < NL; k++) begin
      tests++; if (viol_valid !== 1'b1 || viol_lane !== LW'(k)) begin fails++; $display("FAIL t3_drain_lane[%0d] got=%0d valid=%0b exp=%0d", k, viol_lane, viol_valid, k); end
      tests++; if (viol_rules !== 5'b00010) begin fails++; $display("FAIL t3_drain_rules[%0d] got=%0b exp=00010", k, viol_rules); end
      step(1);
    end
    tests++; if (viol_valid !== 1'b0) begin fails++; $display("FAIL t3_empty got=%0b exp=0", viol_valid); end
    monitor    = '0;
    lane_reset = '1;
    step(1);
    lane_reset = '0;
    for (int l = 0; l < NL; l++) set_lane(l, 5'b00100);
    step(2);
    for (int k = 0; k < NL; k++) begin
      tests++; if (viol_valid !== 1'b1 || viol_lane !== LW'(k)) begin fails++; $display("FAIL t3_burst2_lane[%0d] got=%0d valid=%0b exp=%0d", k, viol_lane, viol_valid, k); end
      tests++; if (lane_release !== 4'(1 << k)) begin fails++; $display("FAIL t3_burst2_release[%0d] got=%0b exp=%0b", k, lane_release, 4'(1 << k)); end
      tests++; if (viol_rules !== 5'b00100) begin fails++; $display("FAIL t3_burst2_rules[%0d] got=%0b exp=00100", k, viol_rules); end
      step(1);
    end
    tests++; if (viol_valid !== 1'b0) begin fails++; $display("FAIL t3_burst2_empty got=%0b exp=0", viol_valid); end
  endtask

  task automatic test_backpressure();
    logic [LW-1:0] exp_lane  [5];
    logic [NR-1:0] exp_rules [5];
    exp_lane  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_rules = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00110};
    do_reset();
    for (int l = 0; l < NL; l++) set_lane(l, 5'b00001);
    step(5);
    set_lane(0, 5'b00011);
    step(1);
    set_lane(0, 5'b00111);
    step(1);
    for (int k = 0; k < 4; k++) begin
      tests++; if (viol_valid !== 1'b1 || viol_lane !== 2'd0 || viol_rules !== 5'b00001 || viol_time !== 16'd1) begin
        fails++; $display("FAIL t4_stable[%0d] got valid=%0b lane=%0d rules=%0b time=%0d exp valid=1 lane=0 rules=00001 time=1", k, viol_valid, viol_lane, viol_rules, viol_time);
      end
      tests++; if (lane_release !== 4'b0000) begin fails++; $display("FAIL t4_no_release[%0d] got=%0b exp=0000", k, lane_release); end
      step(1);
    end
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tests++; if (viol_valid !== 1'b1 || viol_lane !== exp_lane[k] || viol_rules !== exp_rules[k]) begin
        fails++; $display("FAIL t4_drain[%0d] got valid=%0b lane=%0d rules=%0b exp lane=%0d rules=%0b", k, viol_valid, viol_lane, viol_rules, exp_lane[k], exp_rules[k]);
      end
      step(1);
    end
    tests++; if (viol_valid !== 1'b0) begin fails++; $display("FAIL t4_empty got=%0b exp=0", viol_valid); end
    tests++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL t4_drop got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_drop();
    int vseen;
    do_reset();
    for (int l = 0; l < NL; l++) set_lane(l, 5'b00001);
    step(5);
    set_lane(1, 5'b00011);
    step(1);
    set_lane(1, 5'b00000);
    lane_reset[1] = 1'b1;
    step(1);
    lane_reset[1] = 1'b0;
    tests++; if (drop_cnt !== 8'd1) begin fails++; $display("FAIL t5_drop_one got=%0d exp=1", drop_cnt); end
    ready = 1'b1;
    for (int k = 0; k < NL; k++) begin
      tests++; if (viol_valid !== 1'b1 || viol_lane !== LW'(k) || viol_rules !== 5'b00001) begin
        fails++; $display("FAIL t5_drain[%0d] got valid=%0b lane=%0d rules=%0b exp lane=%0d rules=00001", k, viol_valid, viol_lane, viol_rules, k);
      end
      step(1);
    end
    vseen = 0;
    for (int k = 0; k < 3; k++) begin
      if (viol_valid) vseen++;
      step(1);
    end
    tests++; if (vseen !== 0) begin fails++; $display("FAIL t5_no_lane1_record got=%0d exp=0", vseen); end
    vseen = 0;
    for (int i = 0; i < 299; i++) begin
      set_lane(1, 5'b00001);
      step(1);
      if (viol_valid) vseen++;
      set_lane(1, 5'b00000);
      lane_reset[1] = 1'b1;
      step(1);
      lane_reset[1] = 1'b0;
      if (viol_valid) vseen++;
      if (i == 198) begin
        tests++; if (drop_cnt !== 8'd200) begin fails++; $display("FAIL t5_drop_200 got=%0d exp=200", drop_cnt); end
      end
    end
    tests++; if (drop_cnt !== 8'd255) begin fails++; $display("FAIL t5_drop_sat got=%0d exp=255", drop_cnt); end
    tests++; if (vseen !== 0) begin fails++; $display("FAIL t5_loop_records got=%0d exp=0", vseen); end
  endtask

  task automatic test_async_reset();
    monitor    = '0;
    lane_reset = '1;
    ready      = 1'b0;
    step(1);
    lane_reset = '0;
    set_lane(0, 5'b00001);
    set_lane(1, 5'b00001);
    step(3);
    tests++; if (viol_valid !== 1'b1) begin fails++; $display("FAIL t6_pre_valid got=%0b exp=1", viol_valid); end
    tests++; if (drop_cnt !== 8'd255) begin fails++; $display("FAIL t6_pre_drop got=%0d exp=255", drop_cnt); end
    #2;
    monitor = '0;
    rst_ni  = 1'b0;
    #1;
    tests++; if (viol_valid !== 1'b0) begin fails++; $display("FAIL t6_rst_valid got=%0b exp=0", viol_valid); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL t6_rst_irq got=%0b exp=0", irq); end
    tests++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL t6_rst_drop got=%0d exp=0", drop_cnt); end
    step(1);
    tests++; if (viol_valid !== 1'b0 || drop_cnt !== 8'd0 || lane_release !== 4'd0) begin
      fails++; $display("FAIL t6_rst_hold got valid=%0b drop=%0d release=%0b exp 0/0/0", viol_valid, drop_cnt, lane_release);
    end
    rst_ni = 1'b1;
    ready  = 1'b1;
    set_lane(0, 5'b00001);
    step(2);
    tests++; if (viol_valid !== 1'b1 || viol_lane !== 2'd0 || viol_time !== 16'd1) begin
      fails++; $display("FAIL t6_ts_restart got valid=%0b lane=%0d time=%0d exp valid=1 lane=0 time=1", viol_valid, viol_lane, viol_time);
    end
    step(65532);
    set_lane(2, 5'b00001);
    set_lane(3, 5'b00001);
    step(2);
    tests++; if (viol_valid !== 1'b1 || viol_lane !== 2'd2 || viol_time !== 16'hFFFF) begin
      fails++; $display("FAIL t6_ts_max got valid=%0b lane=%0d time=%0h exp valid=1 lane=2 time=ffff", viol_valid, viol_lane, viol_time);
    end
    step(1);
    tests++; if (viol_valid !== 1'b1 || viol_lane !== 2'd3 || viol_time !== 16'h0000) begin
      fails++; $display("FAIL t6_ts_wrap got valid=%0b lane=%0d time=%0h exp valid=1 lane=3 time=0", viol_valid, viol_lane, viol_time);
    end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_edge_detect();
    test_round_robin();
    test_backpressure();
    test_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
